// File: rtl/srrc_rx_slicer_pkg.sv
// Shared constants for the SRRC receive slicer: 4-ASK levels, threshold,
// Gray decision codes, FSM encoding and a saturating accumulator add.
package srrc_rx_slicer_pkg;

  localparam logic signed [17:0] SYMBOL_M3 = 18'h28000;
  localparam logic signed [17:0] SYMBOL_M1 = 18'h38000;
  localparam logic signed [17:0] SYMBOL_P1 = 18'h08000;
  localparam logic signed [17:0] SYMBOL_P3 = 18'h18000;
  localparam logic signed [17:0] SLICE_THR = 18'h10000;

  localparam logic [1:0] GRAY_M3 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [17:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/srrc_rx_slicer_if.sv
// Sample-side inputs and decision-side outputs of the receive slicer.
// Enables are qualifiers, not a handshake: no backpressure exists; sym_valid and
// acc_done are single-cycle strobes and their data is held until the next strobe.
interface srrc_rx_slicer_if;
  import srrc_rx_slicer_pkg::*;

  logic        sam_clk_en;
  logic        sym_clk_en;
  logic [1:0]  sample_phase;
  logic [17:0] rx_in;
  logic [1:0]  sym_out;
  logic [17:0] sym_val;
  logic [17:0] err_out;
  logic        sym_valid;
  logic [31:0] err_acc;
  logic        acc_done;

  modport master (
    output sam_clk_en, sym_clk_en, sample_phase, rx_in,
    input  sym_out, sym_val, err_out, sym_valid, err_acc, acc_done
  );

  modport slave (
    input  sam_clk_en, sym_clk_en, sample_phase, rx_in,
    output sym_out, sym_val, err_out, sym_valid, err_acc, acc_done
  );
endinterface

// File: rtl/srrc_rx_slicer_ask4_slicer.sv
// Combinational 4-ASK decision: Gray code, ideal level, saturated error and |error|
// for a sample x against threshold thr and inner/outer levels lvl1/lvl3.
module ask4_slicer
  import srrc_rx_slicer_pkg::*;
(
  input  logic signed [17:0] x,
  input  logic signed [17:0] thr,
  input  logic signed [17:0] lvl1,
  input  logic signed [17:0] lvl3,
  output logic [1:0]         code,
  output logic signed [17:0] level,
  output logic signed [17:0] err,
  output logic [17:0]        abs_err
);
  logic [18:0] diff;

  always_comb begin
    code  = GRAY_P3;
    level = lvl3;
    if (x >= thr) begin
      code  = GRAY_P3;
      level = lvl3;
    end else if (x >= 18'sd0) begin
      code  = GRAY_P1;
      level = lvl1;
    end else if (x >= -thr) begin
      code  = GRAY_M1;
      level = -lvl1;
    end else begin
      code  = GRAY_M3;
      level = -lvl3;
    end

    // 19-bit difference, clamped back into the 1s17 range
    diff = {x[17], x} - {level[17], level};
    case (diff[18:17])
      2'b01:   err = 18'h1FFFF;
      2'b10:   err = 18'h20000;
      default: err = diff[17:0];
    endcase
    abs_err = err[17] ? (~err + 18'd1) : err;
  end
endmodule

// File: rtl/srrc_rx_slicer.sv
// SRRC receive slicer: phase select, decimation to symbol rate, 4-ASK slicing,
// error output and windowed |error| accumulation. SLICER_ADAPT_EN enables the adaptive threshold.
module srrc_rx_slicer
  import srrc_rx_slicer_pkg::*;
#(
  parameter int FILL_SYMS = 8,
  parameter int ACC_LOG2  = 10
) (
  input  logic             sys_clk,
  input  logic             reset,
  srrc_rx_slicer_if.slave  bus,
  output logic [1:0]       state
);
  localparam int FW = (FILL_SYMS > 1) ? $clog2(FILL_SYMS) : 1;

  state_t             st_q, st_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [1:0]         cnt_q, idx, phase_q, phase_eff;
  logic signed [17:0] hold_q;
  logic               run_sym;
  logic [ACC_LOG2-1:0] win_q;
  logic [31:0]        run_sum_q, sum_nxt, err_acc_q;
  logic [1:0]         sym_out_q, code;
  logic signed [17:0] sym_val_q, err_out_q, level, err;
  logic [17:0]        abs_err;
  logic               sym_valid_q, acc_done_q;
  logic signed [17:0] thr, lvl1, lvl3;

  // A sym_clk_en cycle carries sample index 0 and starts the new phase
  assign idx       = bus.sym_clk_en ? 2'd0 : cnt_q + 2'd1;
  assign phase_eff = bus.sym_clk_en ? bus.sample_phase : phase_q;
  assign run_sym   = bus.sym_clk_en && (st_q == ST_RUN);
  assign sum_nxt   = sat_add32(run_sum_q, abs_err);

`ifdef SLICER_ADAPT_EN
  logic signed [17:0] thr_q;
  logic [17:0]        abs_x;
  logic [18:0]        thr_diff, thr_sum, lvl3_w;

  assign abs_x    = hold_q[17] ? (~hold_q + 18'd1) : hold_q;
  assign thr_diff = {1'b0, abs_x} - {1'b0, thr_q};
  assign thr_sum  = {1'b0, thr_q} + 19'($signed(thr_diff) >>> 4);
  assign lvl3_w   = {1'b0, thr_q} + {2'b00, thr_q[17:1]};
  assign thr      = thr_q;
  assign lvl1     = {1'b0, thr_q[17:1]};
  assign lvl3     = lvl3_w[17] ? 18'h1FFFF : lvl3_w[17:0];

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset)       thr_q <= SLICE_THR;
    else if (run_sym) thr_q <= thr_sum[17] ? 18'h1FFFF : thr_sum[17:0];
  end
`else
  assign thr  = SLICE_THR;
  assign lvl1 = SYMBOL_P1;
  assign lvl3 = SYMBOL_P3;
`endif

  ask4_slicer u_slicer (
    .x       (hold_q),
    .thr     (thr),
    .lvl1    (lvl1),
    .lvl3    (lvl3),
    .code    (code),
    .level   (level),
    .err     (err),
    .abs_err (abs_err)
  );

  always_comb begin
    st_d   = st_q;
    fill_d = fill_q;
    if (bus.sym_clk_en) begin
      case (st_q)
        ST_IDLE: st_d = ST_FILL;
        ST_FILL: begin
          if (fill_q == FW'(FILL_SYMS - 1)) st_d = ST_RUN;
          else                              fill_d = fill_q + FW'(1);
        end
        default: st_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      st_q        <= ST_IDLE;
      fill_q      <= '0;
      cnt_q       <= '0;
      phase_q     <= '0;
      hold_q      <= '0;
      win_q       <= '0;
      run_sum_q   <= '0;
      err_acc_q   <= '0;
      sym_out_q   <= '0;
      sym_val_q   <= '0;
      err_out_q   <= '0;
      sym_valid_q <= 1'b0;
      acc_done_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      fill_q      <= fill_d;
      sym_valid_q <= 1'b0;
      acc_done_q  <= 1'b0;
      if (bus.sam_clk_en) begin
        cnt_q <= idx;
        if (idx == phase_eff) hold_q <= bus.rx_in;
      end
      if (bus.sym_clk_en) phase_q <= bus.sample_phase;
      // Slicer sees hold_q before this cycle's capture
      if (run_sym) begin
        sym_valid_q <= 1'b1;
        sym_out_q   <= code;
        sym_val_q   <= level;
        err_out_q   <= err;
        win_q       <= win_q + ACC_LOG2'(1);
        if (win_q == '1) begin
          err_acc_q  <= sum_nxt;
          acc_done_q <= 1'b1;
          run_sum_q  <= '0;
        end else begin
          run_sum_q  <= sum_nxt;
        end
      end
    end
  end

  assign bus.sym_out   = sym_out_q;
  assign bus.sym_val   = sym_val_q;
  assign bus.err_out   = err_out_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.err_acc   = err_acc_q;
  assign bus.acc_done  = acc_done_q;
  assign state         = st_q;
endmodule

// File: tb/tb_srrc_rx_slicer.sv
// Bench for srrc_rx_slicer (default build): symbol-level reference model checked
// every cycle, plus literal expectations for fill, slicer ties, phase, window and reset.
module tb_srrc_rx_slicer;
  localparam int FILL = 8;
  localparam int ALOG = 2;
  localparam int WIN  = 1 << ALOG;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [1:0] state;
  srrc_rx_slicer_if bus ();

  srrc_rx_slicer #(.FILL_SYMS(FILL), .ACC_LOG2(ALOG)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus),
    .state   (state)
  );

  always #10 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;
  int valid_seen = 0;
  int acc_seen   = 0;
  int gap_max    = 0;
  logic [1:0] ph_sel = 2'd2;

  // reference model state
  logic [1:0]  exp_sym_out, exp_state;
  logic [17:0] exp_sym_val, exp_err;
  logic        exp_valid, exp_done;
  logic [31:0] exp_acc;
  int          n_bound;
  logic [17:0] cur_s [4];
  int          cur_ph, cur_idx;
  logic [17:0] exp_q [$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  task automatic slice_model(input logic [17:0] xv, output logic [1:0] c,
                             output logic [17:0] lv, output logic [17:0] ev, output logic [17:0] av);
    int x, l, e;
    x = $signed(xv);
    if (x >= 65536)       begin c = 2'b10; l =  98304; end
    else if (x >= 0)      begin c = 2'b11; l =  32768; end
    else if (x >= -65536) begin c = 2'b01; l = -32768; end
    else                  begin c = 2'b00; l = -98304; end
    e = x - l;
    if (e > 131071)  e = 131071;
    if (e < -131072) e = -131072;
    lv = 18'(l);
    ev = 18'(e);
    av = 18'((e < 0) ? -e : e);
  endtask

  task automatic model_reset();
    exp_sym_out = '0; exp_sym_val = '0; exp_err = '0;
    exp_valid = 1'b0; exp_done = 1'b0; exp_acc = '0; exp_state = '0;
    n_bound = 0; cur_ph = 0; cur_idx = 0;
    for (int i = 0; i < 4; i++) cur_s[i] = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic sam, input logic sym, input logic [17:0] x, input logic [1:0] ph);
    logic [17:0] av;
    longint s;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (sym) begin
      n_bound++;
      // decision for the symbol just completed, once fill is over
      if (n_bound >= FILL + 2) begin
        slice_model(cur_s[cur_ph], exp_sym_out, exp_sym_val, exp_err, av);
        exp_valid = 1'b1;
        exp_q.push_back(av);
        if (exp_q.size() == WIN) begin
          s = 0;
          foreach (exp_q[i]) s += exp_q[i];
          if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
          exp_acc  = s[31:0];
          exp_done = 1'b1;
          exp_q.delete();
        end
      end
      for (int i = 0; i < 4; i++) cur_s[i] = '0;
      cur_s[0] = x;
      cur_ph   = int'(ph);
      cur_idx  = 0;
    end else if (sam) begin
      cur_idx++;
      if (cur_idx < 4) cur_s[cur_idx] = x;
    end
    exp_state = (n_bound == 0) ? 2'd0 : (n_bound <= FILL) ? 2'd1 : 2'd2;
  endtask

  always @(negedge sys_clk) begin
    if (chk_on) begin
      chk("sym_valid", 32'(bus.sym_valid), 32'(exp_valid));
      chk("acc_done",  32'(bus.acc_done),  32'(exp_done));
      chk("sym_out",   32'(bus.sym_out),   32'(exp_sym_out));
      chk("sym_val",   32'(bus.sym_val),   32'(exp_sym_val));
      chk("err_out",   32'(bus.err_out),   32'(exp_err));
      chk("err_acc",   bus.err_acc,        exp_acc);
      chk("state",     32'(state),         32'(exp_state));
      if (bus.sym_valid === 1'b1) valid_seen++;
      if (bus.acc_done === 1'b1)  acc_seen++;
    end
  end

  task automatic cyc(input logic sam, input logic sym, input logic [17:0] x, input logic [1:0] ph);
    bus.sam_clk_en   = sam;
    bus.sym_clk_en   = sym;
    bus.rx_in        = x;
    bus.sample_phase = ph;
    @(posedge sys_clk);
    #1;
    if (!reset) model_reset();
    else        model_step(sam, sym, x, ph);
  endtask

  task automatic send_sym(input logic [17:0] s0, input logic [17:0] s1,
                          input logic [17:0] s2, input logic [17:0] s3);
    logic [17:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, k == 0, s[k], (k == 0) ? ph_sel : 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, gap_max)) cyc(1'b0, 1'b0, 18'($urandom), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic send_const(input logic [17:0] v, input int n);
    for (int i = 0; i < n; i++) send_sym(v, v, v, v);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sym_out"},   32'(bus.sym_out),   32'd0);
    chk({tag, "_sym_val"},   32'(bus.sym_val),   32'd0);
    chk({tag, "_err_out"},   32'(bus.err_out),   32'd0);
    chk({tag, "_sym_valid"}, 32'(bus.sym_valid), 32'd0);
    chk({tag, "_err_acc"},   bus.err_acc,        32'd0);
    chk({tag, "_acc_done"},  32'(bus.acc_done),  32'd0);
    chk({tag, "_state"},     32'(state),         32'd0);
  endtask

  function automatic logic [17:0] rnd_x();
    case ($urandom_range(0, 7))
      0: return 18'h10000;
      1: return 18'h30000;
      2: return 18'h2FFFF;
      3: return 18'h00000;
      4: return 18'h20000;
      5: return 18'h0FFFF;
      default: return 18'($urandom);
    endcase
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] bv [4];
    logic [1:0]  bc [4];
    bv[0] = 18'h10000; bv[1] = 18'h00000; bv[2] = 18'h30000; bv[3] = 18'h2FFFF;
    bc[0] = 2'b10;     bc[1] = 2'b11;     bc[2] = 2'b01;     bc[3] = 2'b00;

    bus.sam_clk_en = 1'b0; bus.sym_clk_en = 1'b0; bus.rx_in = '0; bus.sample_phase = '0;
    model_reset();
    #1 reset = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 18'h0, 2'd0);
    chk_zero("por");
    reset  = 1'b1;
    chk_on = 1'b1;

    // fill period and steady +0.75
    gap_max = 2; ph_sel = 2'd2;
    send_const(18'h18000, 9);
    chk("fill_no_valid", 32'(valid_seen), 32'd0);
    send_const(18'h18000, 3);
    chk("p3_sym_out", 32'(bus.sym_out), 32'h2);
    chk("p3_sym_val", 32'(bus.sym_val), 32'h18000);
    chk("p3_err",     32'(bus.err_out), 32'h0);
    chk("run_state",  32'(state),       32'h2);
    chk("first_valids", 32'(valid_seen), 32'd3);

    // slicer tie points
    gap_max = 0;
    send_sym(bv[0], bv[0], bv[0], bv[0]);
    for (int i = 0; i < 4; i++) begin
      send_sym(bv[(i + 1) % 4], bv[(i + 1) % 4], bv[(i + 1) % 4], bv[(i + 1) % 4]);
      chk($sformatf("tie_%0d", i), 32'(bus.sym_out), 32'(bc[i]));
    end

    // phase selection on a ramp
    gap_max = 1; ph_sel = 2'd2;
    repeat (3) send_sym(18'h00000, 18'h04000, 18'h08000, 18'h0C000);
    chk("ramp_sym_out", 32'(bus.sym_out), 32'h3);
    chk("ramp_err2",    32'(bus.err_out), 32'h0);
    ph_sel = 2'd3;
    send_sym(18'h00000, 18'h04000, 18'h08000, 18'h0C000);
    chk("ramp_still2",  32'(bus.err_out), 32'h0);
    chk("ramp_val",     32'(bus.sym_val), 32'h08000);
    send_sym(18'h00000, 18'h04000, 18'h08000, 18'h0C000);
    chk("ramp_err3",    32'(bus.err_out), 32'h04000);

    // error window of constant 0.3
    send_const(18'h09999, 9);
    chk("w_err",     32'(bus.err_out), 32'h01999);
    chk("w_err_acc", bus.err_acc,      32'h6664);

    // asynchronous reset mid-window
    send_const(18'h09999, 2);
    @(negedge sys_clk);
    #2 reset = 1'b0;
    #1 chk_zero("mid_rst");
    model_reset();
    repeat (3) cyc(1'b0, 1'b0, 18'h0, 2'd0);
    reset = 1'b1;
    valid_seen = 0; acc_seen = 0;
    send_const(18'h09999, 12);
    chk("rst_no_done",   32'(acc_seen),   32'd0);
    chk("rst_valids",    32'(valid_seen), 32'd3);
    send_const(18'h09999, 1);
    chk("rst_done",      32'(acc_seen),   32'd1);
    chk("rst_err_acc",   bus.err_acc,     32'h6664);

    // randomized symbols, phases and enable gaps
    for (int i = 0; i < 250; i++) begin
      gap_max = $urandom_range(0, 2);
      ph_sel  = 2'($urandom_range(0, 3));
      send_sym(rnd_x(), rnd_x(), rnd_x(), rnd_x());
    end
    repeat (3) cyc(1'b0, 1'b0, 18'h0, 2'd0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
